// File: rtl/async_fifo_pkg.sv
// Shared types for the async_fifo family: read-side FSM states and default data width.
package async_fifo_pkg;

  localparam int DATAWIDTH_DEF = 32;

  typedef enum logic {
    ST_STARTUP = 1'b0,
    ST_RUN     = 1'b1
  } rd_state_e;

endpackage

// File: rtl/stream_skid2.sv
// Two-entry valid/ready buffer (output register plus one skid) with a write port at the tail.
module stream_skid2
  import async_fifo_pkg::*;
#(
  parameter int DW = DATAWIDTH_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [1:0]    occ_o,
  output logic          pop_o
);

  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic [DW-1:0] skid_data_q, skid_data_d;
  logic          pop_s;

  assign pop_s = out_valid_q & ready_i;

  // Pop first, then let the skid entry fall forward, then append the new word at the tail.
  always_comb begin
    out_valid_d  = out_valid_q & ~pop_s;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!out_valid_d && skid_valid_q) begin
      out_valid_d  = 1'b1;
      out_data_d   = skid_data_q;
      skid_valid_d = 1'b0;
    end else begin
      skid_valid_d = skid_valid_q;
    end
    if (push_i) begin
      if (!out_valid_d) begin
        out_valid_d = 1'b1;
        out_data_d  = push_data_i;
      end else if (!skid_valid_d) begin
        skid_valid_d = 1'b1;
        skid_data_d  = push_data_i;
      end else begin
        skid_valid_d = 1'b1;
      end
    end else begin
      out_data_d = out_data_d;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= {DW{1'b0}};
      skid_valid_q <= 1'b0;
      skid_data_q  <= {DW{1'b0}};
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign valid_o = out_valid_q;
  assign data_o  = out_data_q;
  assign occ_o   = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
  assign pop_o   = pop_s;

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-domain consumer for async_fifo: issues fifo_rd safely against lagging flags and
// re-presents the words as a valid/ready stream.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DATAWIDTH      = DATAWIDTH_DEF,
  parameter int STARTUP_CYCLES = 4
) (
  input  logic                 rclk,
  input  logic                 rrstn,
  output logic                 fifo_rd,
  input  logic [DATAWIDTH-1:0] fifo_dout,
  input  logic                 fifo_empty,
  input  logic                 almost_empty,
  output logic                 m_valid,
  output logic [DATAWIDTH-1:0] m_data,
  input  logic                 m_ready,
  output logic [31:0]          rd_count
);

  localparam int CW = $clog2(STARTUP_CYCLES + 1);
  localparam logic [CW-1:0] START_LAST = CW'(STARTUP_CYCLES - 1);

  rd_state_e     state_q;
  logic [CW-1:0] start_cnt_q;
  logic          inflight_q;
  logic [31:0]   rd_count_q;

  logic [1:0]    occ_s;
  logic          pop_s;
  logic [2:0]    used_s;
  logic [2:0]    room_s;
  logic          rd_s;

  // Entries already claimed must fit in the two slots after this cycle's pop; a back-to-back
  // read is only safe when the FIFO held at least 3 words before the previous read.
  assign used_s = {1'b0, occ_s} + {2'b00, inflight_q};
  assign room_s = 3'd1 + {2'b00, pop_s};
  assign rd_s   = (state_q == ST_RUN) && !fifo_empty && (used_s <= room_s) &&
                  (!inflight_q || !almost_empty);

  // Startup hold-off, in-flight tracking and delivered-word counter.
  always_ff @(posedge rclk or negedge rrstn) begin
    if (!rrstn) begin
      state_q     <= ST_STARTUP;
      start_cnt_q <= {CW{1'b0}};
      inflight_q  <= 1'b0;
      rd_count_q  <= 32'd0;
    end else begin
      case (state_q)
        ST_STARTUP: begin
          if (start_cnt_q == START_LAST) begin
            state_q <= ST_RUN;
          end else begin
            start_cnt_q <= start_cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_STARTUP;
      endcase
      inflight_q <= rd_s;
      rd_count_q <= rd_count_q + {31'd0, pop_s};
    end
  end

  stream_skid2 #(.DW(DATAWIDTH)) u_skid (
    .clk_i       (rclk),
    .rst_ni      (rrstn),
    .push_i      (inflight_q),
    .push_data_i (fifo_dout),
    .ready_i     (m_ready),
    .valid_o     (m_valid),
    .data_o      (m_data),
    .occ_o       (occ_s),
    .pop_o       (pop_s)
  );

  assign fifo_rd  = rd_s;
  assign rd_count = rd_count_q;

endmodule
